bicubic_row_accum: RTL and testbench
====================================

BICUBIC_ROW_ACCUM -- requirements
Module: bicubic_row_accum

Interface
REQ-001 Parameter ROWS, 4, number of input beats (kernel rows) summed per output pixel.
REQ-002 Parameter TAPS, 4, number of sign-magnitude products carried per input beat.
REQ-003 Parameter MAG_W, 8, magnitude width of each product and of the output pixel.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 acc_clr  input  1  synchronous clear that discards the partial sum and resets the beat count.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block accepts the beat this cycle.
REQ-009 in_mag  input  TAPS*MAG_W  product magnitudes; tap 0 in the LSBs.
REQ-010 in_sign  input  TAPS  product signs, 1 = negative; bit i belongs to tap i.
REQ-011 out_valid  output  1  output pixel valid.
REQ-012 out_ready  input  1  downstream accepts the pixel.
REQ-013 out_pixel  output  MAG_W  clamped result pixel.
REQ-014 out_clip  output  1  result was clamped, either low or high.

Function
REQ-015 The block SHALL accept a beat when in_valid && in_ready are both high on a rising clk edge.
REQ-016 Each tap SHALL be converted from sign-magnitude to two's complement, with magnitude 0 treated as +0 regardless of sign.
REQ-017 The beat sum SHALL be the signed sum of TAPS taps in MAG_W+4 bits and SHALL never overflow.
REQ-018 The accumulator SHALL be signed, MAG_W+6 bits wide (14 bits at defaults), and exact for ROWS*TAPS full-scale taps.
REQ-019 beat_cnt SHALL count 0..ROWS-1 and SHALL increment on each accepted beat.
REQ-020 beat_cnt SHALL wrap to 0 on the accepted beat where beat_cnt==ROWS-1 (the last beat).
REQ-021 States: ACCUM (beat_cnt has its reset meaning) and the output register full or empty; no other state exists.
REQ-022 On an accepted last beat, the pixel SHALL be computed from accumulator+beat_sum and loaded into the output register.
REQ-023 On an accepted last beat, out_valid SHALL assert the next cycle (latency 1 cycle from the last beat).
REQ-024 On an accepted last beat, the accumulator SHALL restart at 0.
REQ-025 Clamp rule: a total below 0 SHALL give out_pixel=0 and out_clip=1.
REQ-026 Clamp rule: a total above 2^MAG_W-1 SHALL give out_pixel=2^MAG_W-1 and out_clip=1.
REQ-027 Clamp rule: any other total SHALL give out_pixel=total and out_clip=0.
REQ-028 in_ready SHALL equal (beat_cnt!=ROWS-1) || !out_valid || out_ready.
REQ-029 As a consequence of REQ-028, the block SHALL sustain one beat per cycle with out_ready held high.
REQ-030 out_valid, out_pixel and out_clip SHALL hold stable while out_valid && !out_ready.
REQ-031 out_valid SHALL clear after a handshake unless a new pixel is loaded in the same cycle.
REQ-032 acc_clr SHALL clear the accumulator and beat_cnt to 0; a beat accepted in the same cycle SHALL become beat 0 of the new pixel.
REQ-033 acc_clr SHALL NOT affect the output register or out_valid.
REQ-034 Inputs SHALL be ignored while in_valid is low; the accumulator SHALL change only on accepted beats or on acc_clr.

Reset
REQ-035 On rst assertion the block SHALL immediately force accumulator=0, beat_cnt=0, out_valid=0, out_pixel=0 and out_clip=0.
REQ-036 While rst is high, in_ready SHALL read 1 but no beat SHALL be accepted.
REQ-037 Reset mid-pixel SHALL discard all partial sums; the first beat accepted after release SHALL be beat 0.

Structure
REQ-038 Package bicubic_pkg SHALL hold MAG_W, TAPS, ROWS defaults, the derived beat-sum and accumulator widths, and the clamp max constant.
REQ-039 Sub-module bicubic_beat_sum SHALL be purely combinational and hold the sign-magnitude to two's complement conversion plus the TAPS-input adder tree.
REQ-040 All sequential logic (counter, accumulator, output register) SHALL reside in bicubic_row_accum.

Verification
REQ-041 Scenario: beats {+5,+20,+20,+5} then three all-zero beats, out_ready=1 -> out_pixel=50, out_clip=0, out_valid for exactly 1 cycle, 1 cycle after the 4th beat.
REQ-042 Scenario: 16 taps all +255 -> out_pixel=255, out_clip=1, with no accumulator wrap.
REQ-043 Scenario: beat {-30,+10,0,0} then zeros, plus one tap of magnitude 0 with sign=1 -> out_pixel=0, out_clip=1, and the -0 tap contributes 0.
REQ-044 Scenario: out_ready=0 while a second pixel streams in -> in_ready drops only at that pixel's last beat, the first pixel holds stable, and both pixels are delivered in order once out_ready=1.
REQ-045 Scenario: acc_clr pulsed with beat 2 of a pixel ({+100,0,0,0}) -> that beat starts a new pixel, the old partial sum is lost, and the result equals 100 plus the following 3 beats.
REQ-046 Scenario: rst asserted after 2 beats, with out_valid high -> all outputs zero asynchronously; after release, 4 beats of {+1,+1,+1,+1} give out_pixel=16.

Source files
------------

// File: rtl/bicubic_pkg.sv
// bicubic_pkg: shared widths and constants for the bicubic row accumulator
package bicubic_pkg;
    localparam int MAG_W_DEF = 8;
    localparam int TAPS_DEF  = 4;
    localparam int ROWS_DEF  = 4;
    localparam int SUM_W     = MAG_W_DEF + 4;
    localparam int ACC_W     = MAG_W_DEF + 6;
    localparam int PIX_MAX   = (1 << MAG_W_DEF) - 1;
endpackage

// File: rtl/bicubic_beat_sum.sv
// bicubic_beat_sum: sign-magnitude taps to two's complement, summed per beat
module bicubic_beat_sum
    import bicubic_pkg::*;
#(
    parameter int TAPS  = TAPS_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic [TAPS*MAG_W-1:0]  mag,
    input  logic [TAPS-1:0]        sign,
    output logic signed [MAG_W+3:0] sum
);
    localparam int SW = MAG_W + 4;
    // negate only non-zero magnitudes so a -0 tap contributes nothing
    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++)
            sum = sum + ((sign[i] && |mag[i*MAG_W +: MAG_W]) ? -SW'(mag[i*MAG_W +: MAG_W]) : SW'(mag[i*MAG_W +: MAG_W]));
    end
endmodule

// File: rtl/bicubic_row_accum.sv
// bicubic_row_accum: sums ROWS beats of signed taps and emits a clamped pixel
module bicubic_row_accum
    import bicubic_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int TAPS  = TAPS_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TAPS*MAG_W-1:0] in_mag,
    input  logic [TAPS-1:0]       in_sign,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MAG_W-1:0]      out_pixel,
    output logic                  out_clip
);
    localparam int SW = MAG_W + 4;
    localparam int AW = MAG_W + 6;
    localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam logic signed [AW-1:0] MAX_V = AW'((1 << MAG_W) - 1);

    logic [CW-1:0]          beat_cnt, cnt_eff;
    logic signed [AW-1:0]   acc, acc_eff, total;
    logic signed [SW-1:0]   beat_sum;
    logic                   accept, fire_last;

    bicubic_beat_sum #(.TAPS(TAPS), .MAG_W(MAG_W)) u_sum (
        .mag  (in_mag),
        .sign (in_sign),
        .sum  (beat_sum)
    );

    // a beat arriving with acc_clr starts a fresh pixel as beat 0
    always_comb begin
        in_ready  = (beat_cnt != CW'(ROWS-1)) || !out_valid || out_ready;
        accept    = in_valid && in_ready;
        cnt_eff   = acc_clr ? '0 : beat_cnt;
        acc_eff   = acc_clr ? '0 : acc;
        fire_last = accept && (cnt_eff == CW'(ROWS-1));
        total     = acc_eff + AW'(beat_sum);
    end

    // beat counter and partial-sum accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            acc      <= '0;
        end else if (accept) begin
            beat_cnt <= fire_last ? '0 : cnt_eff + CW'(1);
            acc      <= fire_last ? '0 : total;
        end else if (acc_clr) begin
            beat_cnt <= '0;
            acc      <= '0;
        end
    end

    // output register: load clamped pixel on last beat, drop valid on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_clip  <= 1'b0;
        end else if (fire_last) begin
            out_valid <= 1'b1;
            out_pixel <= total < 0 ? '0 : total > MAX_V ? '1 : total[MAG_W-1:0];
            out_clip  <= total < 0 || total > MAX_V;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bicubic_row_accum.sv
// tb_bicubic_row_accum: directed vector table plus multi-cycle corner sequences
module tb_bicubic_row_accum;
    logic        clk = 1'b0, rst = 1'b1, acc_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, out_clip;
    logic [31:0] in_mag = '0;
    logic [3:0]  in_sign = '0;
    logic [7:0]  out_pixel;
    int          checks = 0, passed = 0;

    typedef struct {
        logic [127:0] mag;
        logic [15:0]  sgn;
        int           pix;
        int           clip;
    } vec_t;
    vec_t vt[9];

    bicubic_row_accum dut (
        .clk       (clk),
        .rst       (rst),
        .acc_clr   (acc_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_clip  (out_clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic beat(input logic [31:0] m, input logic [3:0] s);
        in_mag = m;
        in_sign = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vt[0] = '{{96'h0, 32'h05141405}, 16'h0000, 50, 0};
        vt[1] = '{{4{32'hFFFFFFFF}}, 16'h0000, 255, 1};
        vt[2] = '{{96'h0, 32'h00000A1E}, 16'h0005, 0, 1};
        vt[3] = '{{96'h0, 32'h00376464}, 16'h0000, 255, 0};
        vt[4] = '{{96'h0, 32'h00008080}, 16'h0000, 255, 1};
        vt[5] = '{{96'h0, 32'h00000A0A}, 16'h0002, 0, 0};
        vt[6] = '{{32'h00010000, 32'h0000001E, 32'h96000000, 32'h000000C8}, 16'h0080, 81, 0};
        vt[7] = '{{4{32'hFFFFFFFF}}, 16'hFFFF, 0, 1};
        vt[8] = '{{96'h0, 32'h00000700}, 16'h0001, 7, 0};

        // reset state, with a beat offered that must not be taken
        #2;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_pixel", int'(out_pixel), 0);
        chk("rst_clip", int'(out_clip), 0);
        chk("rst_ready", int'(in_ready), 1);
        in_mag = 32'h09090909;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ready_hold", int'(in_ready), 1);
        chk("rst_no_out", int'(out_valid), 0);
        in_valid = 1'b0;
        rst = 1'b0;

        // vector table, one pixel per entry, idle cycle after each
        for (int v = 0; v < 9; v++) begin
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("v%0d_ready_b%0d", v, b), int'(in_ready), 1);
                beat(vt[v].mag[b*32 +: 32], vt[v].sgn[b*4 +: 4]);
                if (b < 3) chk($sformatf("v%0d_early_b%0d", v, b), int'(out_valid), 0);
            end
            chk($sformatf("v%0d_valid", v), int'(out_valid), 1);
            chk($sformatf("v%0d_pixel", v), int'(out_pixel), vt[v].pix);
            chk($sformatf("v%0d_clip", v), int'(out_clip), vt[v].clip);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_one_cycle", v), int'(out_valid), 0);
        end

        // back-to-back pixels with out_ready high: one beat per cycle
        for (int b = 0; b < 4; b++) begin
            chk("bb_ready_a", int'(in_ready), 1);
            beat(32'h01010101, 4'h0);
        end
        chk("bb_a_valid", int'(out_valid), 1);
        chk("bb_a_pixel", int'(out_pixel), 16);
        for (int b = 0; b < 4; b++) begin
            chk("bb_ready_b", int'(in_ready), 1);
            beat(32'h02020202, 4'h0);
            if (b < 3) chk("bb_gap", int'(out_valid), 0);
        end
        chk("bb_b_valid", int'(out_valid), 1);
        chk("bb_b_pixel", int'(out_pixel), 32);
        @(posedge clk);
        #1;
        chk("bb_drain", int'(out_valid), 0);

        // backpressure: first pixel holds while the second streams in
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) beat(32'h01010101, 4'h0);
        chk("bp_p1_valid", int'(out_valid), 1);
        chk("bp_p1_pixel", int'(out_pixel), 16);
        for (int b = 0; b < 3; b++) begin
            chk("bp_ready_early", int'(in_ready), 1);
            beat(32'h02020202, 4'h0);
        end
        chk("bp_ready_last", int'(in_ready), 0);
        in_mag = 32'h02020202;
        in_sign = 4'h0;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_hold_pixel", int'(out_pixel), 16);
        chk("bp_hold_clip", int'(out_clip), 0);
        chk("bp_still_blocked", int'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_p2_valid", int'(out_valid), 1);
        chk("bp_p2_pixel", int'(out_pixel), 32);
        @(posedge clk);
        #1;
        chk("bp_drain", int'(out_valid), 0);

        // acc_clr with beat 2 restarts the pixel from that beat
        beat(32'h01010101, 4'h0);
        beat(32'h01010101, 4'h0);
        acc_clr = 1'b1;
        beat(32'h00000064, 4'h0);
        acc_clr = 1'b0;
        beat(32'h00000001, 4'h0);
        beat(32'h00000001, 4'h0);
        chk("clr_not_early", int'(out_valid), 0);
        out_ready = 1'b0;
        beat(32'h00000001, 4'h0);
        chk("clr_valid", int'(out_valid), 1);
        chk("clr_pixel", int'(out_pixel), 103);
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        chk("clr_keeps_valid", int'(out_valid), 1);
        chk("clr_keeps_pixel", int'(out_pixel), 103);

        // async reset mid-pixel with a pixel held at the output
        beat(32'h05050505, 4'h0);
        beat(32'h05050505, 4'h0);
        in_mag = 32'h05050505;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_pixel", int'(out_pixel), 0);
        chk("arst_clip", int'(out_clip), 0);
        @(posedge clk);
        #1;
        chk("arst_ready", int'(in_ready), 1);
        chk("arst_no_out", int'(out_valid), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            beat(32'h01010101, 4'h0);
            if (b < 3) chk("arst_early", int'(out_valid), 0);
        end
        chk("arst_after_valid", int'(out_valid), 1);
        chk("arst_after_pixel", int'(out_pixel), 16);
        chk("arst_after_clip", int'(out_clip), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
